// File: rtl/ifetch_ctrl_pkg.sv
// Shared sizes, NOP encoding and fetch FSM state encoding for the instruction
// fetch controller.
package ifetch_ctrl_pkg;

  localparam int PC_SIZE    = 32;
  localparam int INSTR_SIZE = 32;

  // addi x0,x0,0
  localparam logic [INSTR_SIZE-1:0] NOP_ENC = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifetch_ctrl.sv
// Single-outstanding instruction fetch controller: issues one word request,
// holds the returned word for decode, and handles redirects without PC math.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [PC_SIZE-1:0]    RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_SIZE-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  output logic [PC_SIZE-1:0]    imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [INSTR_SIZE-1:0] imem_rsp_data,
  output logic                  if_valid,
  output logic [INSTR_SIZE-1:0] if_instr,
  output logic [PC_SIZE-1:0]    if_pc,
  input  logic                  id_ready,
  input  logic [PC_SIZE-1:0]    pc_next,
  input  logic                  instr_nop_sel,
  input  logic                  flush,
  input  logic [PC_SIZE-1:0]    flush_pc
);

  fetch_state_e          state_r;
  fetch_state_e          state_nxt_s;
  logic [PC_SIZE-1:0]    req_addr_r;
  logic [PC_SIZE-1:0]    req_addr_nxt_s;
  logic                  pend_r;
  logic                  pend_nxt_s;
  logic [PC_SIZE-1:0]    pend_pc_r;
  logic [PC_SIZE-1:0]    pend_pc_nxt_s;
  logic                  capture_s;
  logic [INSTR_SIZE-1:0] instr_r;
  logic [PC_SIZE-1:0]    pc_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_REQ;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-datapath decode
  always_comb begin
    state_nxt_s    = state_r;
    req_addr_nxt_s = req_addr_r;
    pend_nxt_s     = pend_r;
    pend_pc_nxt_s  = pend_pc_r;
    capture_s      = 1'b0;
    case (state_r)
      ST_REQ: begin
        if (imem_req_ready) begin
          // A redirect seen while the request was stalled (or right now)
          // makes the accepted word stale, so its response must be dropped.
          if (flush || pend_r) begin
            state_nxt_s    = ST_DROP;
            req_addr_nxt_s = flush ? flush_pc : pend_pc_r;
            pend_nxt_s     = 1'b0;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          if (flush) begin
            pend_nxt_s    = 1'b1;
            pend_pc_nxt_s = flush_pc;
          end else begin
            pend_nxt_s = pend_r;
          end
        end
      end
      ST_WAIT: begin
        if (flush) begin
          req_addr_nxt_s = flush_pc;
          state_nxt_s    = imem_rsp_valid ? ST_REQ : ST_DROP;
        end else if (imem_rsp_valid) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          req_addr_nxt_s = flush_pc;
          state_nxt_s    = ST_REQ;
        end else if (id_ready) begin
          req_addr_nxt_s = pc_next;
          state_nxt_s    = ST_REQ;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_DROP: begin
        if (flush) begin
          req_addr_nxt_s = flush_pc;
        end else begin
          req_addr_nxt_s = req_addr_r;
        end
        if (imem_rsp_valid) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: begin
        state_nxt_s = ST_REQ;
      end
    endcase
  end

  // Fetch address, pending redirect target and held instruction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr_r <= RESET_PC;
      pend_r     <= 1'b0;
      pend_pc_r  <= RESET_PC;
      instr_r    <= NOP_INSTR;
      pc_r       <= RESET_PC;
    end else begin
      req_addr_r <= req_addr_nxt_s;
      pend_r     <= pend_nxt_s;
      pend_pc_r  <= pend_pc_nxt_s;
      if (capture_s) begin
        instr_r <= imem_rsp_data;
        pc_r    <= req_addr_r;
      end
    end
  end

  // Output decode; the request is masked while reset is held
  always_comb begin
    imem_req_valid = 1'b0;
    if_valid       = 1'b0;
    if_instr       = instr_r;
    if ((state_r == ST_REQ) && !rst) begin
      imem_req_valid = 1'b1;
    end else begin
      imem_req_valid = 1'b0;
    end
    if (state_r == ST_HOLD) begin
      if_valid = 1'b1;
    end else begin
      if_valid = 1'b0;
    end
    if (instr_nop_sel) begin
      if_instr = NOP_INSTR;
    end else begin
      if_instr = instr_r;
    end
  end

  assign imem_req_addr = req_addr_r;
  assign if_pc         = pc_r;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed self-checking bench for ifetch_ctrl: normal fetch, stall in HOLD,
// nop substitution and the redirect corner cases.
module tb_ifetch_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [31:0] pc_next;
  logic        instr_nop_sel;
  logic        flush;
  logic [31:0] flush_pc;

  int checks   = 0;
  int failures = 0;

  ifetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .id_ready      (id_ready),
    .pc_next       (pc_next),
    .instr_nop_sel (instr_nop_sel),
    .flush         (flush),
    .flush_pc      (flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    id_ready = 1'b0; pc_next = 32'h0; instr_nop_sel = 1'b0; flush = 1'b0; flush_pc = 32'h0;
    tick(); tick();
    check_eq("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check_eq("rst_if_valid", {31'h0, if_valid}, 32'h0);
    check_eq("rst_if_instr", if_instr, 32'h0000_0013);
    check_eq("rst_if_pc", if_pc, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check_eq("first_req_addr", imem_req_addr, 32'h0);

    // Fetch at 0: handshake, one-cycle response, consume with pc_next=4
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    check_eq("wait_no_req", {31'h0, imem_req_valid}, 32'h0);
    check_eq("wait_no_ifv", {31'h0, if_valid}, 32'h0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093; tick(); imem_rsp_valid = 1'b0;
    check_eq("f0_if_valid", {31'h0, if_valid}, 32'h1);
    check_eq("f0_if_pc", if_pc, 32'h0);
    check_eq("f0_if_instr", if_instr, 32'h0050_0093);
    id_ready = 1'b1; pc_next = 32'h4; tick(); id_ready = 1'b0;
    check_eq("f1_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check_eq("f1_req_addr", imem_req_addr, 32'h4);
    check_eq("f1_ifv_drop", {31'h0, if_valid}, 32'h0);

    // Fetch at 4, then stall for three cycles in HOLD
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0113; tick(); imem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_if_valid", {31'h0, if_valid}, 32'h1);
      check_eq("stall_if_pc", if_pc, 32'h4);
      check_eq("stall_if_instr", if_instr, 32'h0010_0113);
      check_eq("stall_no_req", {31'h0, imem_req_valid}, 32'h0);
    end

    // Nop substitution while consumed, next fetch at 0x100
    instr_nop_sel = 1'b1; id_ready = 1'b1; pc_next = 32'h100; #1;
    check_eq("nop_instr", if_instr, 32'h0000_0013);
    tick(); instr_nop_sel = 1'b0; id_ready = 1'b0;
    check_eq("nop_next_addr", imem_req_addr, 32'h100);
    check_eq("nop_next_valid", {31'h0, imem_req_valid}, 32'h1);

    // Flush in WAIT, re-flush in DROP, response two cycles after first flush
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    flush = 1'b1; flush_pc = 32'h200; tick();
    flush_pc = 32'h280; tick(); flush = 1'b0;
    check_eq("drop_no_req", {31'h0, imem_req_valid}, 32'h0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; tick(); imem_rsp_valid = 1'b0;
    check_eq("wflush_ifv", {31'h0, if_valid}, 32'h0);
    check_eq("wflush_addr", imem_req_addr, 32'h280);
    check_eq("wflush_valid", {31'h0, imem_req_valid}, 32'h1);

    // Flush in REQ while memory stalls for two cycles
    flush = 1'b1; flush_pc = 32'h300; tick(); flush = 1'b0;
    check_eq("rflush_hold1", imem_req_addr, 32'h280);
    check_eq("rflush_valid1", {31'h0, imem_req_valid}, 32'h1);
    tick();
    check_eq("rflush_hold2", imem_req_addr, 32'h280);
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    check_eq("rflush_drop", {31'h0, imem_req_valid}, 32'h0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0001; tick(); imem_rsp_valid = 1'b0;
    check_eq("rflush_ifv", {31'h0, if_valid}, 32'h0);
    check_eq("rflush_addr", imem_req_addr, 32'h300);
    check_eq("rflush_valid", {31'h0, imem_req_valid}, 32'h1);

    // Flush and response in the same WAIT cycle
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    flush = 1'b1; flush_pc = 32'h400; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0002;
    tick(); flush = 1'b0; imem_rsp_valid = 1'b0;
    check_eq("sflush_ifv", {31'h0, if_valid}, 32'h0);
    check_eq("sflush_addr", imem_req_addr, 32'h400);
    check_eq("sflush_valid", {31'h0, imem_req_valid}, 32'h1);

    // Flush in HOLD beats a simultaneous pc_next handshake
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    tick();
    check_eq("s_wait_ifv", {31'h0, if_valid}, 32'h0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_0193; tick(); imem_rsp_valid = 1'b0;
    check_eq("h_if_pc", if_pc, 32'h400);
    check_eq("h_if_instr", if_instr, 32'h0020_0193);
    flush = 1'b1; flush_pc = 32'h500; id_ready = 1'b1; pc_next = 32'h404;
    tick(); flush = 1'b0; id_ready = 1'b0;
    check_eq("hflush_ifv", {31'h0, if_valid}, 32'h0);
    check_eq("hflush_addr", imem_req_addr, 32'h500);

    // Reset mid-transaction; a late response in REQ is ignored
    imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0003; #1;
    check_eq("mrst_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check_eq("mrst_req_addr", imem_req_addr, 32'h0);
    tick(); imem_rsp_valid = 1'b0;
    check_eq("mrst_ifv", {31'h0, if_valid}, 32'h0);
    check_eq("mrst_still_req", {31'h0, imem_req_valid}, 32'h1);
    check_eq("mrst_if_instr", if_instr, 32'h0000_0013);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
